// File: rtl/demux16_pkg.sv
// Shared types and constants for the demux16_collect bit-serial collector.
// The DEMUX16_AUTO_SEL_EN build option is handled in demux16_collect.sv.
package demux16_pkg;

    localparam int N     = 16;
    localparam int SEL_W = $clog2(N);

    localparam logic [N-1:0] ALL_FILLED = {N{1'b1}};

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/demux16_sel_ctr.sv
// Wrapping bit-position counter used when the position is generated internally.
// Clear has priority over increment; wrap from the top index back to 0 is natural.
module demux16_sel_ctr
    import demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] idx
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/demux16_collect.sv
// Bit-serial to 16-bit parallel collector with valid/ready output handshake.
// Define DEMUX16_AUTO_SEL_EN to take positions from an internal counter instead of in_sel.
module demux16_collect #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             dup_err
);
    import demux16_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and out_data is frozen while out_valid.

    state_t           state;
    logic [N-1:0]     fill_mask;
    logic [N-1:0]     next_mask;
    logic [SEL_W-1:0] wr_sel;
    logic             accept;
    logic             dup_hit;

    assign in_ready = (state == FILL) && !rst;
    assign accept   = in_valid && in_ready;

`ifdef DEMUX16_AUTO_SEL_EN
    logic unused_sel;
    assign unused_sel = ^in_sel;

    demux16_sel_ctr u_sel_ctr (
        .clk (clk),
        .rst (rst),
        .clr (flush && (state == FILL)),
        .inc (accept && !flush),
        .idx (wr_sel)
    );

    // Sequential positions can never collide within a frame.
    assign dup_hit = 1'b0;
`else
    assign wr_sel  = in_sel;
    assign dup_hit = fill_mask[wr_sel];
`endif

    assign next_mask = fill_mask | (N'(1) << wr_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            fill_mask <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            dup_err   <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            case (state)
                FILL: begin
                    // A flush in the same cycle as a write drops the write entirely.
                    if (flush) begin
                        fill_mask <= '0;
                    end else if (accept) begin
                        out_data[wr_sel] <= in_bit;
                        fill_mask        <= next_mask;
                        dup_err          <= dup_hit;
                        if (next_mask == ALL_FILLED) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        fill_mask <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux16_collect.sv
// Self-checking bench for demux16_collect: a position-array model checked every
// cycle plus directed literal expectations; honours DEMUX16_AUTO_SEL_EN.
module tb_demux16_collect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic [3:0]  in_sel = 4'd0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        dup_err;

    int checks = 0;
    int failures = 0;
    int frames = 0;
    int dups = 0;
    bit cmp_en = 1'b0;
    bit prev_valid = 1'b0;

    demux16_collect dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .dup_err   (dup_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: which positions hold a bit, what each holds, and
    // whether a finished word is waiting for the consumer.
    bit        m_data[16];
    bit        m_filled[16];
    bit        m_hold;
    bit        m_dup;
    int        m_idx;

    function automatic bit model_full();
        for (int k = 0; k < 16; k++) if (!m_filled[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[k] = m_data[k];
        return w;
    endfunction

    always @(posedge clk) begin
        int pos;
        m_dup = 1'b0;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_data[k] = 1'b0;
                m_filled[k] = 1'b0;
            end
            m_hold = 1'b0;
            m_idx = 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                for (int k = 0; k < 16; k++) m_filled[k] = 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < 16; k++) m_filled[k] = 1'b0;
            m_idx = 0;
        end else if (in_valid) begin
`ifdef DEMUX16_AUTO_SEL_EN
            pos = m_idx;
            m_idx = (m_idx + 1) % 16;
`else
            pos = int'(in_sel);
            m_dup = m_filled[pos];
`endif
            m_data[pos] = in_bit;
            m_filled[pos] = 1'b1;
            if (model_full()) m_hold = 1'b1;
        end
        cmp_en = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_out_valid", 32'(out_valid), 32'(m_hold));
            check("cyc_out_data", 32'(out_data), 32'(model_word()));
            check("cyc_dup_err", 32'(dup_err), 32'(m_dup));
            check("cyc_in_ready", 32'(in_ready), 32'(!m_hold && !rst));
            if (out_valid === 1'b1 && !prev_valid) frames++;
            prev_valid = (out_valid === 1'b1);
            if (dup_err === 1'b1) dups++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int sel, input bit b);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        check("wr_in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sel = 4'(sel);
        in_bit = b;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int f0;
        int d0;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int d0;
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_dup_err", 32'(dup_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        cycle();

`ifdef DEMUX16_AUTO_SEL_EN
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wr(15, (i % 2) == 0);
            if (i == 15 || i == 31) begin
                check("auto_valid", 32'(out_valid), 32'd1);
                check("auto_data", 32'(out_data), 32'h5555);
            end
        end
        cycle();
        cycle();
        check("auto_frames", 32'(frames), 32'd2);
        check("auto_dups", 32'(dups), 32'd0);
`else
        // Ordered fill, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr(i, i[0]);
            if (i == 14) check("ord_not_yet_valid", 32'(out_valid), 32'd0);
        end
        check("ord_valid", 32'(out_valid), 32'd1);
        check("ord_data", 32'(out_data), 32'hAAAA);
        check("ord_hold_ready", 32'(in_ready), 32'd0);
        cycle();
        check("ord_valid_fall", 32'(out_valid), 32'd0);
        check("ord_ready_rise", 32'(in_ready), 32'd1);

        // Reverse order with 5 cycles of backpressure and an ignored write.
        out_ready = 1'b0;
        for (int i = 15; i >= 0; i--) wr(i, 1'b1);
        in_valid = 1'b1;
        in_sel = 4'd0;
        in_bit = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("rev_hold_valid", 32'(out_valid), 32'd1);
            check("rev_hold_data", 32'(out_data), 32'hFFFF);
            check("rev_hold_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("rev_handshake", 32'(out_valid), 32'd0);
        check("rev_data_kept", 32'(out_data), 32'hFFFF);

        // Duplicate write to position 3.
        d0 = dups;
        wr(3, 1'b1);
        wr(3, 1'b0);
        check("dup_pulse", 32'(dup_err), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i != 3) wr(i, 1'b1);
        end
        check("dup_valid", 32'(out_valid), 32'd1);
        check("dup_data", 32'(out_data), 32'hFFF7);
        cycle();
        check("dup_once", 32'(dups - d0), 32'd1);

        // Flush mid-frame, then a full frame of zeros.
        f0 = frames;
        for (int i = 0; i < 8; i++) wr(i, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, 1'b0);
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_data", 32'(out_data), 32'h0000);
        cycle();
        check("flush_one_frame", 32'(frames - f0), 32'd1);

        // Flush coinciding with a write drops the write.
        d0 = dups;
        in_valid = 1'b1;
        in_sel = 4'd15;
        in_bit = 1'b1;
        flush = 1'b1;
        cycle();
        in_valid = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 15; i++) wr(i, 1'b0);
        check("flushwr_dropped", 32'(out_valid), 32'd0);
        wr(15, 1'b0);
        check("flushwr_valid", 32'(out_valid), 32'd1);
        check("flushwr_data", 32'(out_data), 32'h0000);
        cycle();
        check("flushwr_no_dup", 32'(dups - d0), 32'd0);

        // Reset while a word is held.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, 1'b1);
        check("rsthold_valid", 32'(out_valid), 32'd1);
        check("rsthold_data", 32'(out_data), 32'hFFFF);
        rst = 1'b1;
        cycle();
        check("rsthold_valid_clr", 32'(out_valid), 32'd0);
        check("rsthold_data_clr", 32'(out_data), 32'h0000);
        check("rsthold_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rsthold_ready_back", 32'(in_ready), 32'd1);
        cycle();
        cycle();
        check("total_frames", 32'(frames), 32'd6);
        check("total_dups", 32'(dups), 32'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
